ctlr_fsm_rv32i: RTL and testbench



---
 rtl/ctlr_fsm_rv32i.sv | 278 +++++++++++++++++++++++++++
 tb/tb_ctlr_fsm_rv32i.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ctlr_fsm_rv32i.sv
// Multi-cycle RV32I control unit: FETCH/DECODE/EXEC/MEM/WB sequencing over req/ack
// memory ports, with illegal-instruction and bus-timeout traps and a retired-instruction counter.
module ctlr_fsm_rv32i #(
  parameter int CNT_W       = 32,
  parameter int MEM_TIMEOUT = 15,
  parameter bit TRAP_EN     = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [6:0]       op_code,
  input  logic [2:0]       func3,
  input  logic [6:0]       func7,
  output logic             imem_req,
  input  logic             imem_ack,
  output logic             ir_wr,
  output logic             dmem_req,
  output logic             mem_wr,
  input  logic             dmem_ack,
  input  logic             branch_taken,
  output logic             jump,
  output logic             alu_src,
  output logic             wr_reg,
  output logic [2:0]       to_reg,
  output logic [2:0]       branch,
  output logic [3:0]       alu_op,
  output logic             pc_wr,
  output logic [1:0]       pc_src,
  output logic             trap,
  output logic [1:0]       trap_cause,
  output logic [CNT_W-1:0] instret,
  output logic [2:0]       state
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd5
  } state_t;

  typedef enum logic [2:0] {
    K_ALU, K_LOAD, K_STORE, K_BRANCH, K_JAL, K_JALR, K_UPPER
  } kind_t;

  typedef struct packed {
    kind_t       kind;
    logic [3:0]  alu_op;
    logic        alu_src;
    logic [2:0]  to_reg;
    logic [2:0]  branch;
    logic        jump;
  } dec_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam int              TMO_W    = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(MEM_TIMEOUT - 1);

  state_t           state_q, state_d;
  dec_t             dec, dec_q;
  logic             legal;
  logic [TMO_W-1:0] tmo_q;
  logic [1:0]       cause_q, cause_d;
  logic [CNT_W-1:0] instret_q;
  logic             tmo_hit, wait_cyc;
  logic             imem_req_i, ir_wr_i, dmem_req_i, mem_wr_i, wr_reg_i, pc_wr_i;
  logic [1:0]       pc_src_i;

  // sub_ok separates R-type (func7[5] selects SUB) from I-type (func7 is immediate for ADDI).
  function automatic logic [3:0] alu_op_of(input logic [2:0] f3, input logic alt,
                                           input logic sub_ok);
    logic [3:0] op;
    op = 4'd0;
    case (f3)
      3'b000: op = (alt && sub_ok) ? 4'd1 : 4'd0;
      3'b001: op = 4'd2;
      3'b010: op = 4'd3;
      3'b011: op = 4'd4;
      3'b100: op = 4'd5;
      3'b101: op = alt ? 4'd7 : 4'd6;
      3'b110: op = 4'd8;
      3'b111: op = 4'd9;
      default: op = 4'd0;
    endcase
    return op;
  endfunction

  // NOTE: every always_comb output gets a default before the case, so no path can infer a latch.
  always_comb begin
    dec   = '0;
    legal = 1'b1;
    case (op_code)
      OP_R: begin
        legal = (func7 == 7'b0000000) ||
                (func7 == 7'b0100000 && (func3 == 3'b000 || func3 == 3'b101));
        dec.alu_op = alu_op_of(func3, func7[5], 1'b1);
      end
      OP_I: begin
        if (func3 == 3'b001)
          legal = (func7 == 7'b0000000);
        else if (func3 == 3'b101)
          legal = (func7 == 7'b0000000) || (func7 == 7'b0100000);
        dec.alu_op  = alu_op_of(func3, func7[5], 1'b0);
        dec.alu_src = 1'b1;
      end
      OP_LOAD: begin
        dec.kind    = K_LOAD;
        dec.alu_src = 1'b1;
        dec.to_reg  = 3'd1;
      end
      OP_STORE: begin
        dec.kind    = K_STORE;
        dec.alu_src = 1'b1;
      end
      OP_BRANCH: begin
        dec.kind = K_BRANCH;
        case (func3)
          3'b000:  dec.branch = 3'd1;
          3'b001:  dec.branch = 3'd2;
          3'b100:  dec.branch = 3'd3;
          3'b101:  dec.branch = 3'd4;
          3'b110:  dec.branch = 3'd5;
          3'b111:  dec.branch = 3'd6;
          default: legal      = 1'b0;
        endcase
      end
      OP_JAL: begin
        dec.kind   = K_JAL;
        dec.jump   = 1'b1;
        dec.to_reg = 3'd2;
      end
      OP_JALR: begin
        dec.kind    = K_JALR;
        dec.jump    = 1'b1;
        dec.alu_src = 1'b1;
        dec.to_reg  = 3'd2;
      end
      OP_LUI: begin
        dec.kind    = K_UPPER;
        dec.alu_src = 1'b1;
        dec.to_reg  = 3'd3;
      end
      OP_AUIPC: begin
        dec.kind    = K_UPPER;
        dec.alu_src = 1'b1;
        dec.to_reg  = 3'd4;
      end
      default: legal = 1'b0;
    endcase
  end

  assign wait_cyc = (state_q == S_FETCH && !imem_ack) || (state_q == S_MEM && !dmem_ack);
  assign tmo_hit  = TRAP_EN && (tmo_q == TMO_LAST);

  always_comb begin
    state_d    = state_q;
    cause_d    = cause_q;
    imem_req_i = 1'b0;
    ir_wr_i    = 1'b0;
    dmem_req_i = 1'b0;
    mem_wr_i   = 1'b0;
    wr_reg_i   = 1'b0;
    pc_wr_i    = 1'b0;
    pc_src_i   = 2'd0;
    case (state_q)
      S_FETCH: begin
        imem_req_i = 1'b1;
        if (imem_ack) begin
          ir_wr_i = 1'b1;
          state_d = S_DECODE;
        end else if (tmo_hit) begin
          state_d = S_TRAP;
          cause_d = 2'd1;
        end
      end
      S_DECODE: begin
        if (legal) begin
          state_d = S_EXEC;
        end else if (TRAP_EN) begin
          state_d = S_TRAP;
          cause_d = 2'd2;
        end else begin
          pc_wr_i = 1'b1;
          state_d = S_FETCH;
        end
      end
      S_EXEC: begin
        case (dec_q.kind)
          K_BRANCH: begin
            pc_wr_i  = 1'b1;
            pc_src_i = branch_taken ? 2'd1 : 2'd0;
            state_d  = S_FETCH;
          end
          K_LOAD, K_STORE: state_d = S_MEM;
          default:         state_d = S_WB;
        endcase
      end
      S_MEM: begin
        dmem_req_i = 1'b1;
        mem_wr_i   = (dec_q.kind == K_STORE);
        if (dmem_ack) begin
          if (dec_q.kind == K_STORE) begin
            pc_wr_i = 1'b1;
            state_d = S_FETCH;
          end else begin
            state_d = S_WB;
          end
        end else if (tmo_hit) begin
          state_d = S_TRAP;
          cause_d = 2'd1;
        end
      end
      S_WB: begin
        wr_reg_i = 1'b1;
        pc_wr_i  = 1'b1;
        pc_src_i = (dec_q.kind == K_JAL)  ? 2'd1 :
                   (dec_q.kind == K_JALR) ? 2'd2 : 2'd0;
        state_d  = S_FETCH;
      end
      S_TRAP:  state_d = S_TRAP;
      default: state_d = S_FETCH;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_FETCH;
      dec_q     <= '0;
      tmo_q     <= '0;
      cause_q   <= 2'd0;
      instret_q <= '0;
    end else begin
      state_q <= state_d;
      cause_q <= cause_d;
      if (state_q == S_DECODE)
        dec_q <= dec;
      if (state_d != state_q)
        tmo_q <= '0;
      else if (wait_cyc && tmo_q != TMO_LAST)
        tmo_q <= tmo_q + TMO_W'(1);
      if (pc_wr_i)
        instret_q <= instret_q + CNT_W'(1);
    end
  end

  // Reset forces every output low combinationally, before the reset edge lands.
  logic dec_act;
  assign dec_act = !rst && (state_q == S_EXEC || state_q == S_MEM || state_q == S_WB);

  assign imem_req   = !rst && imem_req_i;
  assign ir_wr      = !rst && ir_wr_i;
  assign dmem_req   = !rst && dmem_req_i;
  assign mem_wr     = !rst && mem_wr_i;
  assign wr_reg     = !rst && wr_reg_i;
  assign pc_wr      = !rst && pc_wr_i;
  assign pc_src     = rst ? 2'd0 : pc_src_i;
  assign jump       = dec_act && dec_q.jump;
  assign alu_src    = dec_act && dec_q.alu_src;
  assign to_reg     = dec_act ? dec_q.to_reg : 3'd0;
  assign branch     = dec_act ? dec_q.branch : 3'd0;
  assign alu_op     = dec_act ? dec_q.alu_op : 4'd0;
  assign trap       = !rst && (state_q == S_TRAP);
  assign trap_cause = rst ? 2'd0 : cause_q;
  assign instret    = rst ? '0 : instret_q;
  assign state      = rst ? 3'd0 : state_q;

endmodule

// File: tb/tb_ctlr_fsm_rv32i.sv
// Directed bench for ctlr_fsm_rv32i: a per-cycle vector table over a mixed instruction stream,
// plus hand sequences for timeout, illegal instructions, reset abort and counter wrap.
module tb_ctlr_fsm_rv32i;

  localparam int OP_R = 'h33, OP_I = 'h13, OP_LD = 'h03, OP_ST = 'h23, OP_BR = 'h63;
  localparam int OP_JAL = 'h6F, OP_JALR = 'h67, OP_LUI = 'h37, OP_AUI = 'h17;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [6:0] op_code = '0;
  logic [2:0] func3 = '0;
  logic [6:0] func7 = '0;
  logic       imem_ack = 1'b0, dmem_ack = 1'b0, branch_taken = 1'b0;

  logic        imem_req_a, ir_wr_a, dmem_req_a, mem_wr_a, jump_a, alu_src_a, wr_reg_a, pc_wr_a, trap_a;
  logic [2:0]  to_reg_a, branch_a, state_a;
  logic [3:0]  alu_op_a;
  logic [1:0]  pc_src_a, trap_cause_a;
  logic [31:0] instret_a;

  logic        imem_req_b, ir_wr_b, dmem_req_b, mem_wr_b, jump_b, alu_src_b, wr_reg_b, pc_wr_b, trap_b;
  logic [2:0]  to_reg_b, branch_b, state_b;
  logic [3:0]  alu_op_b;
  logic [1:0]  pc_src_b, trap_cause_b;
  logic [3:0]  instret_b;

  ctlr_fsm_rv32i #(.CNT_W(32), .MEM_TIMEOUT(15), .TRAP_EN(1'b1)) dut_a (
    .clk(clk), .rst(rst), .op_code(op_code), .func3(func3), .func7(func7),
    .imem_req(imem_req_a), .imem_ack(imem_ack), .ir_wr(ir_wr_a),
    .dmem_req(dmem_req_a), .mem_wr(mem_wr_a), .dmem_ack(dmem_ack),
    .branch_taken(branch_taken), .jump(jump_a), .alu_src(alu_src_a), .wr_reg(wr_reg_a),
    .to_reg(to_reg_a), .branch(branch_a), .alu_op(alu_op_a), .pc_wr(pc_wr_a),
    .pc_src(pc_src_a), .trap(trap_a), .trap_cause(trap_cause_a), .instret(instret_a),
    .state(state_a)
  );

  ctlr_fsm_rv32i #(.CNT_W(4), .MEM_TIMEOUT(15), .TRAP_EN(1'b0)) dut_b (
    .clk(clk), .rst(rst), .op_code(op_code), .func3(func3), .func7(func7),
    .imem_req(imem_req_b), .imem_ack(imem_ack), .ir_wr(ir_wr_b),
    .dmem_req(dmem_req_b), .mem_wr(mem_wr_b), .dmem_ack(dmem_ack),
    .branch_taken(branch_taken), .jump(jump_b), .alu_src(alu_src_b), .wr_reg(wr_reg_b),
    .to_reg(to_reg_b), .branch(branch_b), .alu_op(alu_op_b), .pc_wr(pc_wr_b),
    .pc_src(pc_src_b), .trap(trap_b), .trap_cause(trap_cause_b), .instret(instret_b),
    .state(state_b)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] st;
    logic       ireq, irw, dreq, mwr, wreg, pcw;
    logic [1:0] psrc;
    logic [3:0] aop;
    logic       asrc;
    logic [2:0] treg;
    logic [2:0] br;
    logic       jmp;
    logic [7:0] iret;
  } obs_t;

  typedef struct {
    string      name;
    logic [6:0] op;
    logic [2:0] f3;
    logic [6:0] f7;
    logic       ia, da, bt;
    obs_t       exp;
  } vec_t;

  obs_t obs_a;
  assign obs_a = {state_a, imem_req_a, ir_wr_a, dmem_req_a, mem_wr_a, wr_reg_a, pc_wr_a,
                  pc_src_a, alu_op_a, alu_src_a, to_reg_a, branch_a, jump_a, instret_a[7:0]};

  vec_t vecs[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic av(input string name, input int op, input int f3, input int f7,
                    input int ia, input int da, input int bt, input int st,
                    input int ireq, input int irw, input int dreq, input int mwr,
                    input int wreg, input int pcw, input int psrc, input int aop,
                    input int asrc, input int treg, input int br, input int jmp, input int iret);
    vec_t v;
    v.name = name;
    v.op = 7'(op); v.f3 = 3'(f3); v.f7 = 7'(f7);
    v.ia = 1'(ia); v.da = 1'(da); v.bt = 1'(bt);
    v.exp.st = 3'(st); v.exp.ireq = 1'(ireq); v.exp.irw = 1'(irw);
    v.exp.dreq = 1'(dreq); v.exp.mwr = 1'(mwr); v.exp.wreg = 1'(wreg);
    v.exp.pcw = 1'(pcw); v.exp.psrc = 2'(psrc); v.exp.aop = 4'(aop);
    v.exp.asrc = 1'(asrc); v.exp.treg = 3'(treg); v.exp.br = 3'(br);
    v.exp.jmp = 1'(jmp); v.exp.iret = 8'(iret);
    vecs.push_back(v);
  endtask

  // Holds rst across one rising edge; outputs must read zero while it is high.
  task automatic do_reset(input string name);
    @(negedge clk);
    rst = 1'b1; imem_ack = 1'b1; dmem_ack = 1'b1;
    #1;
    check({name, "_forced_zero"}, 64'(obs_a), 64'd0);
    check({name, "_trap_zero"}, 64'({trap_a, trap_cause_a}), 64'd0);
  endtask

  task automatic cyc(input int op, input int f3, input int f7, input logic ia,
                     input logic da, input logic bt);
    @(negedge clk);
    rst = 1'b0; op_code = 7'(op); func3 = 3'(f3); func7 = 7'(f7);
    imem_ack = ia; dmem_ack = da; branch_taken = bt;
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int reqs;
    int bad_op[4], bad_f3[4], bad_f7[4];

    //  name      op      f3 f7    ia da bt  st ireq irw dreq mwr wreg pcw psrc aop asrc treg br jmp iret
    av("add_f",   OP_R,   0, 0,    1, 1, 0,  0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    av("add_d",   OP_R,   0, 0,    1, 1, 0,  1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    av("add_e",   OP_R,   0, 0,    1, 1, 0,  2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    av("add_w",   OP_R,   0, 0,    1, 1, 0,  4, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0);
    av("sub_f",   OP_R,   0, 'h20, 1, 1, 0,  0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    av("sub_d",   OP_R,   0, 'h20, 1, 1, 0,  1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    av("sub_e",   OP_R,   0, 'h20, 1, 1, 0,  2, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1);
    av("sub_w",   OP_R,   0, 'h20, 1, 1, 0,  4, 0, 0, 0, 0, 1, 1, 0, 1, 0, 0, 0, 0, 1);
    av("lw_f",    OP_LD,  2, 0,    1, 1, 0,  0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2);
    av("lw_d",    OP_LD,  2, 0,    1, 1, 0,  1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2);
    av("lw_e",    OP_LD,  2, 0,    1, 1, 0,  2, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 2);
    av("lw_m1",   OP_LD,  2, 0,    1, 0, 0,  3, 0, 0, 1, 0, 0, 0, 0, 0, 1, 1, 0, 0, 2);
    av("lw_m2",   OP_LD,  2, 0,    1, 0, 0,  3, 0, 0, 1, 0, 0, 0, 0, 0, 1, 1, 0, 0, 2);
    av("lw_m3",   OP_LD,  2, 0,    1, 0, 0,  3, 0, 0, 1, 0, 0, 0, 0, 0, 1, 1, 0, 0, 2);
    av("lw_m4",   OP_LD,  2, 0,    1, 1, 0,  3, 0, 0, 1, 0, 0, 0, 0, 0, 1, 1, 0, 0, 2);
    av("lw_w",    OP_LD,  2, 0,    1, 1, 0,  4, 0, 0, 0, 0, 1, 1, 0, 0, 1, 1, 0, 0, 2);
    av("bne1_f",  OP_BR,  1, 0,    1, 1, 1,  0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3);
    av("bne1_d",  OP_BR,  1, 0,    1, 1, 1,  1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3);
    av("bne1_e",  OP_BR,  1, 0,    1, 1, 1,  2, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 2, 0, 3);
    av("bne0_f",  OP_BR,  1, 0,    1, 1, 0,  0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4);
    av("bne0_d",  OP_BR,  1, 0,    1, 1, 0,  1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4);
    av("bne0_e",  OP_BR,  1, 0,    1, 1, 0,  2, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 2, 0, 4);
    av("sw_f0",   OP_ST,  2, 0,    0, 1, 0,  0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5);
    av("sw_f1",   OP_ST,  2, 0,    1, 1, 0,  0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5);
    av("sw_d",    OP_ST,  2, 0,    1, 1, 0,  1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5);
    av("sw_e",    OP_ST,  2, 0,    1, 1, 0,  2, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 5);
    av("sw_m",    OP_ST,  2, 0,    1, 1, 0,  3, 0, 0, 1, 1, 0, 1, 0, 0, 1, 0, 0, 0, 5);
    av("jal_f",   OP_JAL, 0, 0,    1, 1, 0,  0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 6);
    av("jal_d",   OP_JAL, 0, 0,    1, 1, 0,  1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 6);
    av("jal_e",   OP_JAL, 0, 0,    1, 1, 0,  2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2, 0, 1, 6);
    av("jal_w",   OP_JAL, 0, 0,    1, 1, 0,  4, 0, 0, 0, 0, 1, 1, 1, 0, 0, 2, 0, 1, 6);
    av("jalr_f",  OP_JALR,0, 0,    1, 1, 0,  0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 7);
    av("jalr_d",  OP_JALR,0, 0,    1, 1, 0,  1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 7);
    av("jalr_e",  OP_JALR,0, 0,    1, 1, 0,  2, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2, 0, 1, 7);
    av("jalr_w",  OP_JALR,0, 0,    1, 1, 0,  4, 0, 0, 0, 0, 1, 1, 2, 0, 1, 2, 0, 1, 7);
    av("lui_f",   OP_LUI, 0, 0,    1, 1, 0,  0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 8);
    av("lui_d",   OP_LUI, 0, 0,    1, 1, 0,  1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 8);
    av("lui_e",   OP_LUI, 0, 0,    1, 1, 0,  2, 0, 0, 0, 0, 0, 0, 0, 0, 1, 3, 0, 0, 8);
    av("lui_w",   OP_LUI, 0, 0,    1, 1, 0,  4, 0, 0, 0, 0, 1, 1, 0, 0, 1, 3, 0, 0, 8);
    av("aui_f",   OP_AUI, 0, 0,    1, 1, 0,  0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 9);
    av("aui_d",   OP_AUI, 0, 0,    1, 1, 0,  1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 9);
    av("aui_e",   OP_AUI, 0, 0,    1, 1, 0,  2, 0, 0, 0, 0, 0, 0, 0, 0, 1, 4, 0, 0, 9);
    av("aui_w",   OP_AUI, 0, 0,    1, 1, 0,  4, 0, 0, 0, 0, 1, 1, 0, 0, 1, 4, 0, 0, 9);
    av("srai_f",  OP_I,   5, 'h20, 1, 1, 0,  0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 10);
    av("srai_d",  OP_I,   5, 'h20, 1, 1, 0,  1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 10);
    av("srai_e",  OP_I,   5, 'h20, 1, 1, 0,  2, 0, 0, 0, 0, 0, 0, 0, 7, 1, 0, 0, 0, 10);
    av("srai_w",  OP_I,   5, 'h20, 1, 1, 0,  4, 0, 0, 0, 0, 1, 1, 0, 7, 1, 0, 0, 0, 10);
    av("and_f",   OP_R,   7, 0,    1, 1, 0,  0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 11);
    av("and_d",   OP_R,   7, 0,    1, 1, 0,  1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 11);
    av("and_e",   OP_R,   7, 0,    1, 1, 0,  2, 0, 0, 0, 0, 0, 0, 0, 9, 0, 0, 0, 0, 11);
    av("and_w",   OP_R,   7, 0,    1, 1, 0,  4, 0, 0, 0, 0, 1, 1, 0, 9, 0, 0, 0, 0, 11);
    av("end_f",   OP_R,   0, 0,    0, 0, 0,  0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 12);

    do_reset("rst0");
    foreach (vecs[i]) begin
      cyc(vecs[i].op, vecs[i].f3, vecs[i].f7, vecs[i].ia, vecs[i].da, vecs[i].bt);
      check(vecs[i].name, 64'(obs_a), 64'(vecs[i].exp));
    end

    // Fetch never acknowledged: 15 request cycles, then a sticky bus-timeout trap.
    do_reset("rst1");
    reqs = 0;
    for (int i = 0; i < 40; i++) begin
      cyc(OP_R, 0, 0, 1'b0, 1'b0, 1'b0);
      if (trap_a) break;
      if (imem_req_a) reqs++;
    end
    check("tmo_req_cycles", 64'(reqs), 64'd15);
    check("tmo_trap", 64'({trap_a, trap_cause_a, state_a}), 64'({1'b1, 2'd1, 3'd5}));
    check("tmo_req_low", 64'(imem_req_a), 64'd0);
    check("tmo_disabled_b", 64'({imem_req_b, state_b, trap_b}), 64'({1'b1, 3'd0, 1'b0}));
    cyc(OP_R, 0, 0, 1'b1, 1'b1, 1'b0);
    check("trap_ignores_ack", 64'({state_a, ir_wr_a, trap_a}), 64'({3'd5, 1'b0, 1'b1}));
    do_reset("rst2");
    cyc(OP_R, 0, 0, 1'b0, 1'b0, 1'b0);
    check("trap_cleared", 64'({state_a, trap_a, trap_cause_a, imem_req_a}),
          64'({3'd0, 1'b0, 2'd0, 1'b1}));

    // Ack arriving in the very cycle the timeout would fire takes priority.
    do_reset("rst3");
    for (int i = 0; i < 14; i++) cyc(OP_R, 0, 0, 1'b0, 1'b0, 1'b0);
    cyc(OP_R, 0, 0, 1'b1, 1'b0, 1'b0);
    check("ack_wins_irwr", 64'(ir_wr_a), 64'd1);
    cyc(OP_R, 0, 0, 1'b0, 1'b0, 1'b0);
    check("ack_wins_state", 64'({state_a, trap_a}), 64'({3'd1, 1'b0}));

    // Illegal encodings: dut_a traps with cause 2, dut_b retires them as NOPs.
    bad_op = '{'h7F, OP_R, OP_I, OP_BR};
    bad_f3 = '{0, 1, 1, 3};
    bad_f7 = '{0, 'h20, 'h20, 0};
    for (int k = 0; k < 4; k++) begin
      do_reset("rst_ill");
      cyc(bad_op[k], bad_f3[k], bad_f7[k], 1'b1, 1'b0, 1'b0);
      cyc(bad_op[k], bad_f3[k], bad_f7[k], 1'b1, 1'b0, 1'b0);
      check($sformatf("ill%0d_decode_a", k), 64'({state_a, pc_wr_a}), 64'({3'd1, 1'b0}));
      check($sformatf("ill%0d_decode_b", k), 64'({pc_wr_b, pc_src_b}), 64'({1'b1, 2'd0}));
      cyc(bad_op[k], bad_f3[k], bad_f7[k], 1'b0, 1'b0, 1'b0);
      check($sformatf("ill%0d_trap_a", k), 64'({state_a, trap_a, trap_cause_a, imem_req_a}),
            64'({3'd5, 1'b1, 2'd2, 1'b0}));
      check($sformatf("ill%0d_nop_b", k), 64'({state_b, instret_b, trap_b}),
            64'({3'd0, 4'd1, 1'b0}));
    end

    // Reset during the MEM wait of a store aborts it without retiring.
    do_reset("rst4");
    cyc(OP_ST, 2, 0, 1'b1, 1'b0, 1'b0);
    cyc(OP_ST, 2, 0, 1'b1, 1'b0, 1'b0);
    cyc(OP_ST, 2, 0, 1'b1, 1'b0, 1'b0);
    cyc(OP_ST, 2, 0, 1'b1, 1'b0, 1'b0);
    check("sw_in_mem", 64'({state_a, dmem_req_a, mem_wr_a}), 64'({3'd3, 1'b1, 1'b1}));
    @(negedge clk);
    rst = 1'b1; dmem_ack = 1'b1;
    #1;
    check("sw_rst_no_pcwr", 64'({pc_wr_a, dmem_req_a}), 64'd0);
    cyc(OP_ST, 2, 0, 1'b0, 1'b0, 1'b0);
    check("sw_rst_after", 64'({state_a, instret_a, imem_req_a}), 64'({3'd0, 32'd0, 1'b1}));

    // Sixteen retires wrap the 4-bit counter of dut_b back to zero.
    do_reset("rst5");
    for (int k = 0; k < 16; k++) begin
      for (int c = 0; c < 3; c++) begin
        cyc(OP_BR, 0, 0, 1'b1, 1'b0, 1'b0);
        if (k == 15 && c == 0) check("wrap_pre", 64'(instret_b), 64'd15);
      end
    end
    cyc(OP_BR, 0, 0, 1'b0, 1'b0, 1'b0);
    check("wrap_b", 64'(instret_b), 64'd0);
    check("nowrap_a", 64'(instret_a), 64'd16);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
